// File: rtl/instr_fetch_queue_if.sv
// Instruction-memory and issue-stage signals of the fetch queue.
// master = fetch queue side, slave = memory / issue stage side.
interface instr_fetch_queue_if;
    logic [3:0]  PC;
    logic [15:0] output_instruction;
    logic        issue_valid;
    logic        issue_ready;
    logic [15:0] issue_instr;
    logic [3:0]  issue_op;
    logic [3:0]  issue_rd;
    logic [3:0]  issue_rs;
    logic [3:0]  issue_rt;

    modport master (
        output PC, issue_valid, issue_instr, issue_op, issue_rd, issue_rs, issue_rt,
        input  output_instruction, issue_ready
    );

    modport slave (
        input  PC, issue_valid, issue_instr, issue_op, issue_rd, issue_rs, issue_rt,
        output output_instruction, issue_ready
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: fetches PROG_LEN words into an in-order FIFO feeding issue.
// Optional issue stall counter enabled by defining ISSUE_STALL_CNT_EN.
module instr_fetch_queue #(
    parameter int DEPTH    = 4,
    parameter int PROG_LEN = 4
) (
    input  logic                   clk1,
    input  logic                   rst,
    input  logic                   start,
    instr_fetch_queue_if.master    bus,
    output logic                   busy,
    output logic                   done,
    output logic [3:0]             count,
    output logic [15:0]            stall_cycles
);
    localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0]    DEPTH_L = 5'(DEPTH);
    localparam logic [3:0]    LAST_PC = 4'(PROG_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t         r_state, w_state_nxt;
    logic [3:0]     r_pc;
    logic           r_pending;
    logic [3:0]     r_count;
    logic [AW-1:0]  r_wptr, r_rptr;
    logic [15:0]    r_fifo [DEPTH];

    logic           w_req, w_push, w_pop, w_launch;
    logic [3:0]     w_count_nxt;

    // Credit counts words in flight; same-cycle pops are deliberately not credited.
    assign w_req       = (r_state == S_FETCH) &&
                         ({1'b0, r_count} + {4'b0, r_pending} + 5'd1 <= DEPTH_L);
    assign w_push      = r_pending;
    assign w_pop       = (r_count != 4'd0) && bus.issue_ready;
    assign w_launch    = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_count_nxt = r_count + {3'b0, w_push} - {3'b0, w_pop};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_FETCH;
            S_FETCH: if (w_req && (r_pc == LAST_PC)) w_state_nxt = S_DRAIN;
            S_DRAIN: if ((w_count_nxt == 4'd0) && !r_pending) w_state_nxt = S_DONE;
            S_DONE:  if (start) w_state_nxt = S_FETCH;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pc      <= 4'd0;
            r_pending <= 1'b0;
            r_count   <= 4'd0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            for (int i = 0; i < DEPTH; i++) r_fifo[i] <= 16'h0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_req;
            r_count   <= w_count_nxt;
            if (w_launch)   r_pc <= 4'd0;
            else if (w_req) r_pc <= r_pc + 4'd1;
            if (w_push) begin
                r_fifo[r_wptr] <= bus.output_instruction;
                r_wptr         <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
        end
    end

    assign bus.PC          = r_pc;
    assign bus.issue_valid = (r_count != 4'd0);
    assign bus.issue_instr = r_fifo[r_rptr];
    assign bus.issue_op    = bus.issue_instr[15:12];
    assign bus.issue_rd    = bus.issue_instr[11:8];
    assign bus.issue_rs    = bus.issue_instr[7:4];
    assign bus.issue_rt    = bus.issue_instr[3:0];
    assign busy            = (r_state == S_FETCH) || (r_state == S_DRAIN);
    assign done            = (r_state == S_DONE);
    assign count           = r_count;

`ifdef ISSUE_STALL_CNT_EN
    logic [15:0] r_stall;

    always_ff @(posedge clk1) begin
        if (rst || start)
            r_stall <= 16'h0;
        else if (bus.issue_valid && !bus.issue_ready && (r_stall != 16'hFFFF))
            r_stall <= r_stall + 16'd1;
    end

    assign stall_cycles = r_stall;
`else
    assign stall_cycles = 16'h0;
`endif
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: three instances (PROG_LEN 4, 8, 16) with memory models.
module tb_instr_fetch_queue;
`ifdef ISSUE_STALL_CNT_EN
    localparam logic [15:0] STALL_EXP = 16'd5;
`else
    localparam logic [15:0] STALL_EXP = 16'd0;
`endif

    logic clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    logic rst, start4, start8, start16, rdy4, rdy8, rdy16;
    logic busy4, busy8, busy16, done4, done8, done16;
    logic [3:0]  cnt4, cnt8, cnt16;
    logic [15:0] st4, st8, st16;
    logic [15:0] mem4 [4];
    logic [15:0] mem8 [8];
    logic [15:0] mem16 [16];
    logic [15:0] q4, q8r, q16;
    logic [15:0] iss8 [$];
    logic [15:0] iss16 [$];
    logic [3:0]  max8;
    int n_vec = 0;
    int n_err = 0;

    instr_fetch_queue_if if4();
    instr_fetch_queue_if if8();
    instr_fetch_queue_if if16();

    instr_fetch_queue #(.DEPTH(4), .PROG_LEN(4)) dut4 (
        .clk1(clk1), .rst(rst), .start(start4), .bus(if4),
        .busy(busy4), .done(done4), .count(cnt4), .stall_cycles(st4));
    instr_fetch_queue #(.DEPTH(4), .PROG_LEN(8)) dut8 (
        .clk1(clk1), .rst(rst), .start(start8), .bus(if8),
        .busy(busy8), .done(done8), .count(cnt8), .stall_cycles(st8));
    instr_fetch_queue #(.DEPTH(4), .PROG_LEN(16)) dut16 (
        .clk1(clk1), .rst(rst), .start(start16), .bus(if16),
        .busy(busy16), .done(done16), .count(cnt16), .stall_cycles(st16));

    // Synchronous-read memories: word for PC sampled at edge c appears in cycle c+1.
    always @(posedge clk1) begin
        q4  <= mem4[if4.PC[1:0]];
        q8r <= mem8[if8.PC[2:0]];
        q16 <= mem16[if16.PC];
    end
    assign if4.output_instruction  = q4;
    assign if8.output_instruction  = q8r;
    assign if16.output_instruction = q16;
    assign if4.issue_ready  = rdy4;
    assign if8.issue_ready  = rdy8;
    assign if16.issue_ready = rdy16;

    always @(posedge clk1) begin
        if (!rst && if8.issue_valid && if8.issue_ready)   iss8.push_back(if8.issue_instr);
        if (!rst && if16.issue_valid && if16.issue_ready) iss16.push_back(if16.issue_instr);
    end

    always @(negedge clk1) if (cnt8 > max8) max8 <= cnt8;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk1);
    endtask

    task automatic chk_iss8(input string tag);
        chk({tag, "_n"}, iss8.size(), 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("%s_w%0d", tag, i), (i < iss8.size()) ? iss8[i] : 16'hDEAD, mem8[i]);
    endtask

    initial begin
        mem4[0] = 16'h2123; mem4[1] = 16'h0345; mem4[2] = 16'h0267; mem4[3] = 16'h089A;
        for (int i = 0; i < 8; i++)  mem8[i]  = 16'hC0D0 + 16'(i * 3);
        for (int i = 0; i < 16; i++) mem16[i] = 16'(i * 16'h1111) ^ 16'h0F0F;
        max8 = 4'd0;
        rst = 1'b1; start4 = 1'b0; start8 = 1'b0; start16 = 1'b0;
        rdy4 = 1'b1; rdy8 = 1'b0; rdy16 = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();

        // reset state
        chk("rst_pc", if4.PC, 0);
        chk("rst_valid", if4.issue_valid, 0);
        chk("rst_instr", if4.issue_instr, 0);
        chk("rst_count", cnt4, 0);
        chk("rst_busy", busy4, 0);
        chk("rst_done", done4, 0);
        chk("rst_stall", st4, 0);

        // A: 4-word program, ready high, start in cycle 0
        start4 = 1'b1;
        cyc(); start4 = 1'b0;
        chk("A_pc_c1", if4.PC, 0); chk("A_busy_c1", busy4, 1);
        cyc();
        chk("A_pc_c2", if4.PC, 1); chk("A_valid_c2", if4.issue_valid, 0);
        cyc();
        chk("A_pc_c3", if4.PC, 2); chk("A_valid_c3", if4.issue_valid, 1);
        chk("A_instr_c3", if4.issue_instr, 16'h2123);
        chk("A_op", if4.issue_op, 2); chk("A_rd", if4.issue_rd, 1);
        chk("A_rs", if4.issue_rs, 2); chk("A_rt", if4.issue_rt, 3);
        cyc();
        chk("A_pc_c4", if4.PC, 3); chk("A_instr_c4", if4.issue_instr, 16'h0345);
        cyc();
        chk("A_pc_c5", if4.PC, 4); chk("A_instr_c5", if4.issue_instr, 16'h0267);
        cyc();
        chk("A_instr_c6", if4.issue_instr, 16'h089A); chk("A_done_c6", done4, 0);
        cyc();
        chk("A_done_c7", done4, 1); chk("A_valid_c7", if4.issue_valid, 0);
        chk("A_busy_c7", busy4, 0); chk("A_pc_c7", if4.PC, 4);

        // B: 8-word program with ready low until the FIFO fills
        rdy8 = 1'b0; start8 = 1'b1;
        cyc(); start8 = 1'b0;
        repeat (7) cyc();
        chk("B_count", cnt8, 4); chk("B_pc", if8.PC, 4);
        chk("B_valid", if8.issue_valid, 1); chk("B_head", if8.issue_instr, mem8[0]);
        chk("B_stall", st8, STALL_EXP); chk("B_none_issued", iss8.size(), 0);
        rdy8 = 1'b1;
        for (int i = 0; i < 40 && !done8; i++) cyc();
        chk("B_done", done8, 1);
        chk_iss8("B");

        // C: ready toggling 1,0,1,0
        iss8.delete();
        rdy8 = 1'b1; start8 = 1'b1;
        cyc(); start8 = 1'b0;
        for (int i = 0; i < 60 && !done8; i++) begin
            rdy8 = ~rdy8;
            cyc();
        end
        chk("C_done", done8, 1);
        chk_iss8("C");

        // D: reset while count=2 and one word in flight
        iss8.delete();
        rdy8 = 1'b0; start8 = 1'b1;
        cyc(); start8 = 1'b0;
        repeat (3) cyc();
        chk("D_count_c4", cnt8, 2); chk("D_pc_c4", if8.PC, 3);
        rst = 1'b1;
        cyc(); rst = 1'b0;
        chk("D_count", cnt8, 0); chk("D_valid", if8.issue_valid, 0);
        chk("D_busy", busy8, 0); chk("D_done", done8, 0);
        chk("D_pc", if8.PC, 0); chk("D_instr", if8.issue_instr, 0);
        cyc();
        chk("D_no_late_push", cnt8, 0); chk("D_idle_busy", busy8, 0);
        rdy8 = 1'b1; start8 = 1'b1;
        cyc(); start8 = 1'b0;
        for (int i = 0; i < 40 && !done8; i++) cyc();
        chk("D_redone", done8, 1);
        chk_iss8("D");

        // E: 16-word program, PC wrap
        start16 = 1'b1;
        cyc(); start16 = 1'b0;
        for (int i = 0; i < 80 && !done16; i++) cyc();
        chk("E_done", done16, 1); chk("E_pc", if16.PC, 0);
        chk("E_n", iss16.size(), 16);
        for (int i = 0; i < 16; i++)
            chk($sformatf("E_w%0d", i), (i < iss16.size()) ? iss16[i] : 16'hDEAD, mem16[i]);

        chk("max_count8", max8, 4);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
